// File: rtl/fsm_onehot_pkg.sv
// Elaboration-time helpers for the one-hot pattern detector: pattern length limits,
// the KMP failure function and the per-destination source masks for the transition table.
package fsm_onehot_pkg;

  localparam int unsigned PAT_LEN_MIN = 2;
  localparam int unsigned PAT_LEN_MAX = 16;
  localparam int unsigned ST_MAX      = PAT_LEN_MAX + 1;

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic logic pat_bit(logic [15:0] pattern, int unsigned pat_len, int unsigned i);
    return pattern[4'(pat_len - 1 - i)];
  endfunction

  // Longest proper suffix of the k-bit prefix that is also a prefix of the pattern.
  function automatic int unsigned failure(logic [15:0] pattern, int unsigned pat_len,
                                          int unsigned k);
    int unsigned best;
    logic        ok;
    best = 0;
    for (int unsigned m = 1; m < k; m++) begin
      ok = 1'b1;
      for (int unsigned i = 0; i < m; i++) begin
        if (pat_bit(pattern, pat_len, i) != pat_bit(pattern, pat_len, k - m + i)) ok = 1'b0;
      end
      if (ok) best = m;
    end
    return best;
  endfunction

  // Next matched-prefix length from S_k on input bit b.
  function automatic int unsigned next_idx(logic [15:0] pattern, int unsigned pat_len,
                                           int unsigned overlap, int unsigned k, logic b);
    int unsigned j;
    j = (k == pat_len && overlap == 0) ? 0 : k;
    if (j == pat_len) j = failure(pattern, pat_len, j);
    for (int unsigned it = 0; it < ST_MAX; it++) begin
      if (j > 0 && pat_bit(pattern, pat_len, j) != b) j = failure(pattern, pat_len, j);
    end
    return (pat_bit(pattern, pat_len, j) == b) ? j + 1 : 0;
  endfunction

  // Set of source states that move to dst when the input bit is b.
  function automatic logic [ST_MAX-1:0] src_mask(logic [15:0] pattern, int unsigned pat_len,
                                                 int unsigned overlap, int unsigned dst,
                                                 logic b);
    logic [ST_MAX-1:0] m;
    m = '0;
    for (int unsigned k = 0; k <= pat_len; k++) begin
      m[5'(k)] = (next_idx(pattern, pat_len, overlap, k, b) == dst);
    end
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         areset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != '1) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fsm_onehot_detect.sv
// Serial pattern detector with a one-hot Moore FSM whose transition table is built at
// elaboration from PATTERN; counts matches and flags corrupted state encodings.
module fsm_onehot_detect
  import fsm_onehot_pkg::*;
#(
  parameter int unsigned          PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0]   PATTERN = 3'b101,
  parameter int unsigned          OVERLAP = 1,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic               clk,
  input  logic               areset_n,
  input  logic               clr,
  input  logic               in_valid,
  input  logic               in,
  output logic [PAT_LEN:0]   state,
  output logic               out,
  output logic [CNT_W-1:0]   hit_count,
  output logic               onehot_err
);

  localparam int unsigned NS      = PAT_LEN + 1;
  localparam logic [15:0] PAT_EXT = 16'(PATTERN);

  if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_len
    $error("fsm_onehot_detect: PAT_LEN must be within 2..16");
  end
  if (OVERLAP > 1) begin : g_bad_overlap
    $error("fsm_onehot_detect: OVERLAP must be 0 or 1");
  end

  logic [NS-1:0] nxt_c;
  logic [NS-1:0] state_nxt;
  logic          err_nxt;
  logic          legal_c;
  logic          hit_c;

  // One OR-of-terms per destination state, selected by the elaborated source masks.
  for (genvar j = 0; j < NS; j++) begin : g_next
    localparam logic [ST_MAX-1:0] M1 = src_mask(PAT_EXT, PAT_LEN, OVERLAP, j, 1'b1);
    localparam logic [ST_MAX-1:0] M0 = src_mask(PAT_EXT, PAT_LEN, OVERLAP, j, 1'b0);
    assign nxt_c[j] = ((|(state & M1[NS-1:0])) & in) | ((|(state & M0[NS-1:0])) & ~in);
  end

  assign legal_c = (state != '0) && ((state & (state - NS'(1))) == '0);

  // Priority: clear, then illegal-encoding recovery, then qualified data.
  always_comb begin
    state_nxt = state;
    err_nxt   = onehot_err;
    hit_c     = 1'b0;
    if (clr) begin
      state_nxt = NS'(1);
      err_nxt   = 1'b0;
    end else if (!legal_c) begin
      state_nxt = NS'(1);
      err_nxt   = 1'b1;
    end else if (in_valid) begin
      state_nxt = nxt_c;
      hit_c     = nxt_c[PAT_LEN];
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state      <= NS'(1);
      onehot_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      onehot_err <= err_nxt;
    end
  end

  assign out = state[PAT_LEN];

  sat_counter #(
    .W (CNT_W)
  ) u_hit_cnt (
    .clk      (clk),
    .areset_n (areset_n),
    .clr      (clr),
    .inc      (hit_c),
    .count    (hit_count)
  );

endmodule

// File: tb/tb_fsm_onehot_detect.sv
// Scoreboard bench for fsm_onehot_detect: four configurations share one stimulus stream,
// expectations come from a suffix-matching reference model.
module tb_fsm_onehot_detect;

  logic clk = 1'b0;
  logic areset_n = 1'b1;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic in = 1'b0;

  logic [3:0] st0, st1;
  logic [4:0] st2;
  logic [2:0] st3;
  logic       o0, o1, o2, o3;
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;
  logic       e0, e1, e2, e3;

  always #5 clk = ~clk;

  fsm_onehot_detect u_d0 (
    .clk(clk), .areset_n(areset_n), .clr(clr), .in_valid(in_valid), .in(in),
    .state(st0), .out(o0), .hit_count(c0), .onehot_err(e0));

  fsm_onehot_detect #(.OVERLAP(0)) u_d1 (
    .clk(clk), .areset_n(areset_n), .clr(clr), .in_valid(in_valid), .in(in),
    .state(st1), .out(o1), .hit_count(c1), .onehot_err(e1));

  fsm_onehot_detect #(.PAT_LEN(4), .PATTERN(4'b1101)) u_d2 (
    .clk(clk), .areset_n(areset_n), .clr(clr), .in_valid(in_valid), .in(in),
    .state(st2), .out(o2), .hit_count(c2), .onehot_err(e2));

  fsm_onehot_detect #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2)) u_d3 (
    .clk(clk), .areset_n(areset_n), .clr(clr), .in_valid(in_valid), .in(in),
    .state(st3), .out(o3), .hit_count(c3), .onehot_err(e3));

  logic [31:0] gst [4];
  logic [31:0] gcnt [4];
  logic        gout [4];
  logic        gerr [4];

  always_comb begin
    gst[0] = 32'(st0);  gst[1] = 32'(st1);  gst[2] = 32'(st2);  gst[3] = 32'(st3);
    gcnt[0] = 32'(c0);  gcnt[1] = 32'(c1);  gcnt[2] = 32'(c2);  gcnt[3] = 32'(c3);
    gout[0] = o0;       gout[1] = o1;       gout[2] = o2;       gout[3] = o3;
    gerr[0] = e0;       gerr[1] = e1;       gerr[2] = e2;       gerr[3] = e3;
  end

  int unsigned L    [4] = '{3, 3, 4, 2};
  logic [15:0] P    [4] = '{16'b101, 16'b101, 16'b1101, 16'b11};
  int unsigned OV   [4] = '{1, 0, 1, 1};
  int unsigned CMAX [4] = '{255, 255, 255, 3};

  int unsigned ms [4];
  int unsigned mc [4];
  logic        me [4];

  typedef struct {
    int unsigned d;
    logic [31:0] st;
    logic [31:0] cnt;
    logic        o;
    logic        e;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Longest suffix of (matched prefix + b) that is a pattern prefix, found by brute force.
  function automatic int unsigned model_next(int unsigned l, logic [15:0] p, int unsigned ov,
                                             int unsigned k, logic b);
    logic        s [17];
    int unsigned k0, n, best;
    logic        ok;
    k0 = (k == l && ov == 0) ? 0 : k;
    for (int unsigned i = 0; i < k0; i++) s[i] = p[l - 1 - i];
    s[k0] = b;
    n = k0 + 1;
    best = 0;
    for (int unsigned m = 1; m <= n && m <= l; m++) begin
      ok = 1'b1;
      for (int unsigned i = 0; i < m; i++) if (s[n - m + i] != p[l - 1 - i]) ok = 1'b0;
      if (ok) best = m;
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      ms[d] = 0; mc[d] = 0; me[d] = 1'b0;
    end
  endtask

  task automatic push_all();
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      e.d   = d;
      e.st  = 32'(1) << ms[d];
      e.cnt = mc[d];
      e.o   = (ms[d] == L[d]);
      e.e   = me[d];
      sb.push_back(e);
    end
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (sb.size() == 0) begin
        check_eq({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check_eq($sformatf("%s.d%0d.state", tag, e.d), gst[e.d], e.st);
        check_eq($sformatf("%s.d%0d.out", tag, e.d), 32'(gout[e.d]), 32'(e.o));
        check_eq($sformatf("%s.d%0d.count", tag, e.d), gcnt[e.d], e.cnt);
        check_eq($sformatf("%s.d%0d.err", tag, e.d), 32'(gerr[e.d]), 32'(e.e));
      end
    end
  endtask

  task automatic step(input logic v, input logic b, input string tag);
    int unsigned nk;
    @(negedge clk);
    clr = 1'b0; in_valid = v; in = b;
    if (v) begin
      for (int d = 0; d < 4; d++) begin
        nk = model_next(L[d], P[d], OV[d], ms[d], b);
        if (nk == L[d] && mc[d] < CMAX[d]) mc[d]++;
        ms[d] = nk;
      end
    end
    push_all();
    @(posedge clk); #1;
    pop_cmp(tag);
  endtask

  task automatic do_clr(input string tag);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in = 1'b1;
    model_reset();
    push_all();
    @(posedge clk); #1;
    pop_cmp(tag);
    clr = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1 areset_n = 1'b0;
    #1;
    push_all();
    pop_cmp("reset");
    @(negedge clk) areset_n = 1'b1;

    // 1,0,1,0,1: overlapping vs non-overlapping
    step(1, 1, "a1"); step(1, 0, "a2"); step(1, 1, "a3"); step(1, 0, "a4"); step(1, 1, "a5");
    check_eq("ovl_hits", 32'(c0), 32'd2);
    check_eq("novl_hits", 32'(c1), 32'd1);

    // 1,1,1,0,1 against 1101
    do_clr("clr_b");
    step(1, 1, "b1"); step(1, 1, "b2"); step(1, 1, "b3"); step(1, 0, "b4"); step(1, 1, "b5");
    check_eq("p4_state", 32'(st2), 32'b10000);

    // 1,0,1 with idle gaps between bits
    do_clr("clr_c");
    step(1, 1, "c1"); step(0, 0, "c_gap1"); step(0, 1, "c_gap2");
    step(1, 0, "c2"); step(0, 1, "c_gap3"); step(1, 1, "c3");
    check_eq("gap_state", 32'(st0), 32'b1000);
    check_eq("gap_hits", 32'(c0), 32'd1);

    // counter saturation on 11 with CNT_W=2
    do_clr("clr_d");
    for (int i = 0; i < 5; i++) step(1, 1, $sformatf("d%0d", i + 1));
    check_eq("sat_hits", 32'(c3), 32'd3);

    // corrupted encoding recovers to S0 regardless of in_valid, error is sticky
    @(negedge clk);
    in_valid = 1'b0;
    force u_d0.state = 4'b0110;
    #1 release u_d0.state;
    ms[0] = 0; me[0] = 1'b1;
    push_all();
    @(posedge clk); #1;
    pop_cmp("illegal");
    step(1, 1, "e1"); step(1, 0, "e2");
    do_clr("clr_e");

    // async reset mid-pattern drops progress
    step(1, 1, "f1"); step(1, 0, "f2");
    @(negedge clk);
    #2 areset_n = 1'b0;
    #1;
    model_reset();
    push_all();
    pop_cmp("async_rst");
    @(negedge clk) areset_n = 1'b1;
    step(1, 1, "g1"); step(1, 0, "g2"); step(1, 1, "g3");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_onehot_detect.md
FSM_ONEHOT_DETECT -- requirements
Module: fsm_onehot_detect

Interface
REQ-001 SHALL provide parameter PAT_LEN, default 3, pattern length in bits (legal 2..16).
REQ-002 SHALL provide parameter PATTERN, default 3'b101, PAT_LEN-bit pattern whose MSB is the first bit received.
REQ-003 SHALL provide parameter OVERLAP, default 1; 1 = overlapping matches, 0 = non-overlapping matches.
REQ-004 SHALL provide parameter CNT_W, default 8, hit-counter width.
REQ-005 SHALL have port clk, input, 1, single clock; all flops are rising-edge.
REQ-006 SHALL have port areset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port clr, input, 1, synchronous clear.
REQ-008 SHALL have port in_valid, input, 1, qualifies in.
REQ-009 SHALL have port in, input, 1, serial data bit.
REQ-010 SHALL have port state, output, PAT_LEN+1, registered one-hot state; bit k = S_k, meaning k pattern bits matched.
REQ-011 SHALL have port out, output, 1, match indication, equal to state[PAT_LEN] (Moore).
REQ-012 SHALL have port hit_count, output, CNT_W, saturating count of entries into S_PAT_LEN.
REQ-013 SHALL have port onehot_err, output, 1, sticky flag for an illegal state encoding.

Function
REQ-014 SHALL update state only on clk edges where in_valid=1; with in_valid=0, state, out and hit_count SHALL hold.
REQ-015 From S_k with k<PAT_LEN, bit b equal to PATTERN[PAT_LEN-1-k] SHALL go to S_(k+1).
REQ-016 From S_k on any other bit, the next state SHALL be S_j, where j = length of the longest proper suffix of (matched prefix + b) that is also a pattern prefix (KMP failure rule).
REQ-017 From S_PAT_LEN, OVERLAP=1 SHALL apply the REQ-016 rule to the full pattern plus b.
REQ-018 From S_PAT_LEN, OVERLAP=0 SHALL transition exactly as from S_0.
REQ-019 out SHALL assert in the cycle after the clock edge that accepts the final pattern bit; out has no combinational path from in.
REQ-020 hit_count SHALL increment by 1 on each accepted transition into S_PAT_LEN, including S_PAT_LEN to S_PAT_LEN, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-021 Illegal state (zero or multiple bits set), when seen at a clock edge, SHALL force next state to S_0 and set onehot_err, regardless of in_valid; hit_count SHALL NOT increment on that edge.
REQ-022 Priority SHALL be clr > illegal-state recovery > in_valid update.
REQ-023 clr=1 SHALL set state=S_0, hit_count=0 and onehot_err=0 at the next edge, ignoring in/in_valid that cycle.
REQ-024 All transition-table contents SHALL be resolved at elaboration from PATTERN/PAT_LEN/OVERLAP; no runtime pattern storage.
REQ-025 Illegal parameter values (PAT_LEN outside 2..16, OVERLAP not 0/1) SHALL cause an elaboration error.

Reset
REQ-026 areset_n=0 SHALL asynchronously force state=S_0 (only bit 0 set), out=0, hit_count=0, onehot_err=0.
REQ-027 Deassertion of areset_n SHALL take effect at the next clk edge; the first accepted bit after release is treated as the first stream bit.
REQ-028 Reset asserted mid-pattern SHALL discard partial-match progress; no match SHALL be credited.

Structure
REQ-029 Package fsm_onehot_pkg SHALL hold the elaboration-time failure-function and next-state-index function, plus the PAT_LEN limit constants.
REQ-030 The saturating counter SHALL be a sub-module sat_counter (parameter W; inputs inc, clr).
REQ-031 Next-state logic SHALL be a per-bit OR of (state[k] & bit condition) terms, one assign per state bit, generated from the package table.

Verification
REQ-032 Defaults (101, OVERLAP=1), stream 1,0,1,0,1 all valid -> out high after bits 3 and 5, hit_count=2; states follow S1,S2,S3,S2,S3.
REQ-033 Same stream with OVERLAP=0 -> out high after bit 3 only, hit_count=1; state after bit 4 is S0.
REQ-034 PAT_LEN=4, PATTERN=4'b1101, stream 1,1,1,0,1 -> state S1,S2,S2,S3,S4; out high after bit 5.
REQ-035 Defaults, in_valid toggled low between bits of 1,0,1 -> identical final state and count to the gapless case; state held during gaps.
REQ-036 CNT_W=2, stream 1,1,1,1,1 with PATTERN=2'b11, OVERLAP=1 -> hit_count 1,2,3,3 saturated.
REQ-037 Force state=4'b0110 -> next edge state=S0 and onehot_err=1; it remains set until clr, after which onehot_err=0 and hit_count=0; areset_n pulse mid-pattern -> state=S0 immediately, no hit.
